morse_decoder: RTL and testbench



---
 rtl/morse_decoder.sv | 152 +++++++++++++++
 tb/tb_morse_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Morse receiver for letters A-H: measures mark/space runs per unit tick,
// assembles dot/dash symbols and decodes each letter at the letter gap.
module morse_decoder #(
  parameter int unsigned DOT_UNITS  = 1,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 3,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       dot_dash_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LEN  = CNT_W'(DOT_UNITS);
  localparam logic [CNT_W-1:0] DASH_LEN = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_UNITS);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] mark_cnt, mark_cnt_nxt, mark_inc;
  logic [CNT_W-1:0] space_cnt, space_cnt_nxt, space_inc;
  logic [3:0]       pat, pat_nxt;
  logic [2:0]       sym_cnt, sym_cnt_nxt;
  logic             err, err_nxt;
  logic [2:0]       letter_nxt;
  logic             valid_nxt, error_nxt;
  logic             match;
  logic [2:0]       match_code;

  // Saturating run-length increments
  assign mark_inc  = (mark_cnt  == CNT_MAX) ? mark_cnt  : mark_cnt  + CNT_ONE;
  assign space_inc = (space_cnt == CNT_MAX) ? space_cnt : space_cnt + CNT_ONE;

  // Letter lookup on (symbol count, pattern); unused pattern bits are always zero
  always_comb begin
    match      = 1'b1;
    match_code = 3'd0;
    case ({sym_cnt, pat})
      {3'd2, 4'b0001}: match_code = 3'd0;
      {3'd4, 4'b1000}: match_code = 3'd1;
      {3'd4, 4'b1010}: match_code = 3'd2;
      {3'd3, 4'b0100}: match_code = 3'd3;
      {3'd1, 4'b0000}: match_code = 3'd4;
      {3'd4, 4'b0010}: match_code = 3'd5;
      {3'd3, 4'b0110}: match_code = 3'd6;
      {3'd4, 4'b0000}: match_code = 3'd7;
      default:         match      = 1'b0;
    endcase
  end

  // Next-state, symbol store and decode; everything advances only on bit_tick
  always_comb begin
    state_nxt     = state;
    mark_cnt_nxt  = mark_cnt;
    space_cnt_nxt = space_cnt;
    pat_nxt       = pat;
    sym_cnt_nxt   = sym_cnt;
    err_nxt       = err;
    letter_nxt    = letter;
    valid_nxt     = 1'b0;
    error_nxt     = 1'b0;
    if (bit_tick) begin
      case (state)
        IDLE: begin
          if (dot_dash_in) begin
            state_nxt    = MARK;
            mark_cnt_nxt = CNT_ONE;
            pat_nxt      = 4'd0;
            sym_cnt_nxt  = 3'd0;
            err_nxt      = 1'b0;
          end
        end
        MARK: begin
          if (dot_dash_in) begin
            mark_cnt_nxt = mark_inc;
            if (mark_inc > DASH_LEN) err_nxt = 1'b1;
          end else begin
            if ((mark_cnt != DOT_LEN) && (mark_cnt != DASH_LEN)) err_nxt = 1'b1;
            if (sym_cnt == 3'd4) begin
              err_nxt = 1'b1;
            end else begin
              pat_nxt     = {pat[2:0], (mark_cnt == DASH_LEN)};
              sym_cnt_nxt = sym_cnt + 3'd1;
            end
            state_nxt     = SPACE;
            space_cnt_nxt = CNT_ONE;
          end
        end
        SPACE: begin
          if (!dot_dash_in) begin
            space_cnt_nxt = space_inc;
            if (space_inc == GAP_LEN) begin
              if (!err && match) begin
                letter_nxt = match_code;
                valid_nxt  = 1'b1;
              end else begin
                error_nxt  = 1'b1;
              end
              state_nxt   = IDLE;
              pat_nxt     = 4'd0;
              sym_cnt_nxt = 3'd0;
              err_nxt     = 1'b0;
            end
          end else begin
            if (space_cnt != CNT_ONE) err_nxt = 1'b1;
            state_nxt    = MARK;
            mark_cnt_nxt = CNT_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      mark_cnt     <= '0;
      space_cnt    <= '0;
      pat          <= 4'd0;
      sym_cnt      <= 3'd0;
      err          <= 1'b0;
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      letter_error <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      mark_cnt     <= mark_cnt_nxt;
      space_cnt    <= space_cnt_nxt;
      pat          <= pat_nxt;
      sym_cnt      <= sym_cnt_nxt;
      err          <= err_nxt;
      letter       <= letter_nxt;
      letter_valid <= valid_nxt;
      letter_error <= error_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed letter table, corner
// sequences, and randomized letters against a run-length reference model.
module tb_morse_decoder;

  localparam int DOT  = 1;
  localparam int DASH = 3;
  localparam int GAP  = 3;

  logic       clock;
  logic       reset;
  logic       bit_tick;
  logic       dot_dash_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  morse_decoder #(.DOT_UNITS(DOT), .DASH_UNITS(DASH), .GAP_UNITS(GAP), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .bit_tick(bit_tick), .dot_dash_in(dot_dash_in),
    .letter(letter), .letter_valid(letter_valid), .letter_error(letter_error), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: letter-level view built from run lengths and a symbol list
  string pats [8];
  bit        m_in;
  bit        m_rv;
  int        m_rl;
  int        m_syms [$];
  bit        m_bad;
  logic [2:0] m_letter;
  bit        m_valid;
  bit        m_error;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_rv = 0; m_rl = 0; m_syms.delete(); m_bad = 0;
    m_letter = 3'd0; m_valid = 0; m_error = 0;
  endtask

  task automatic model_decode();
    string s;
    int    k;
    s = "";
    k = -1;
    for (int i = 0; i < m_syms.size(); i++) s = {s, (m_syms[i] != 0) ? "1" : "0"};
    if (!m_bad && m_syms.size() <= 4)
      for (int j = 0; j < 8; j++) if (pats[j] == s) k = j;
    if (k >= 0) begin
      m_letter = 3'(k);
      m_valid  = 1;
    end else begin
      m_error = 1;
    end
  endtask

  task automatic model_tick(input bit s);
    m_valid = 0;
    m_error = 0;
    if (!m_in) begin
      if (s) begin
        m_in = 1; m_rv = 1; m_rl = 1; m_syms.delete(); m_bad = 0;
      end
    end else if (s == m_rv) begin
      m_rl++;
      if (m_rv && m_rl > DASH) m_bad = 1;
      if (!m_rv && m_rl == GAP) begin
        model_decode();
        m_in = 0;
      end
    end else if (m_rv) begin
      if (m_rl == DOT) m_syms.push_back(0);
      else if (m_rl == DASH) m_syms.push_back(1);
      else m_bad = 1;
      m_rv = 0;
      m_rl = 1;
    end else begin
      if (m_rl != 1) m_bad = 1;
      m_rv = 1;
      m_rl = 1;
    end
  endtask

  // One clock: drive, update model at the edge, check all outputs 1 time unit later
  task automatic step(input logic t, input logic d);
    bit_tick    = t;
    dot_dash_in = d;
    @(posedge clock);
    if (!reset) model_reset();
    else if (t) model_tick(d);
    else begin m_valid = 0; m_error = 0; end
    #1;
    chk("letter", 32'(letter), 32'(m_letter));
    chk("letter_valid", 32'(letter_valid), 32'(m_valid));
    chk("letter_error", 32'(letter_error), 32'(m_error));
    chk("busy", 32'(busy), 32'(m_in));
  endtask

  task automatic feed(input bit s);
    while ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, s);
  endtask

  typedef struct {
    string      name;
    string      bits;
    bit         exp_valid;
    logic [2:0] exp_letter;
  } vec_t;

  vec_t vecs [$];

  task automatic run_table();
    int vcnt, ecnt, pos;
    foreach (vecs[v]) begin
      vcnt = 0; ecnt = 0; pos = -1;
      for (int i = 0; i < vecs[v].bits.len(); i++) begin
        step(1'b1, vecs[v].bits[i] == "1");
        if (letter_valid) begin vcnt++; pos = i; end
        if (letter_error) begin ecnt++; pos = i; end
      end
      chk({vecs[v].name, "_valid_cnt"}, 32'(vcnt), vecs[v].exp_valid ? 32'd1 : 32'd0);
      chk({vecs[v].name, "_error_cnt"}, 32'(ecnt), vecs[v].exp_valid ? 32'd0 : 32'd1);
      chk({vecs[v].name, "_letter"}, 32'(letter), 32'(vecs[v].exp_letter));
      chk({vecs[v].name, "_pulse_pos"}, 32'(pos), 32'(vecs[v].bits.len() - 1));
      chk({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_random(input int n_letters);
    string p;
    int    corrupt, ml, sl;
    for (int n = 0; n < n_letters; n++) begin
      p = pats[$urandom_range(0, 7)];
      corrupt = $urandom_range(0, 9);
      if (corrupt == 0) p = {p, ($urandom_range(0, 1) != 0) ? "1" : "0"};
      for (int j = 0; j < p.len(); j++) begin
        ml = (p[j] == "1") ? DASH : DOT;
        if (corrupt == 1 && j == 0) ml = $urandom_range(2, 10);
        repeat (ml) feed(1'b1);
        if (j != p.len() - 1) begin
          sl = (corrupt == 2 && j == 0) ? 2 : 1;
          repeat (sl) feed(1'b0);
        end
      end
      repeat (GAP) feed(1'b0);
      repeat ($urandom_range(0, 2)) feed(1'b0);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b0;
        step(1'b1, 1'b1);
        reset = 1'b1;
      end
    end
  endtask

  logic [2:0] saved;
  bit         pulse_seen;

  initial begin
    pats = '{"01", "1000", "1010", "100", "0", "0010", "110", "0000"};
    model_reset();
    reset = 1'b0;
    bit_tick = 1'b0;
    dot_dash_in = 1'b0;
    repeat (3) step(1'b1, 1'b1);
    chk("reset_letter", 32'(letter), 32'd0);
    chk("reset_valid", 32'(letter_valid), 32'd0);
    chk("reset_error", 32'(letter_error), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0);

    vecs.push_back('{"E",        "1000",                 1, 3'd4});
    vecs.push_back('{"C",        "11101011101000",       1, 3'd2});
    vecs.push_back('{"A",        "10111000",             1, 3'd0});
    vecs.push_back('{"H",        "1010101000",           1, 3'd7});
    vecs.push_back('{"mark2",    "11000",                0, 3'd7});
    vecs.push_back('{"fivedots", "101010101000",         0, 3'd7});
    vecs.push_back('{"B",        "111010101000",         1, 3'd1});
    vecs.push_back('{"fourdash", "111011101110111000",   0, 3'd1});
    vecs.push_back('{"D",        "1110101000",           1, 3'd3});
    vecs.push_back('{"F",        "101011101000",         1, 3'd5});
    vecs.push_back('{"space2",   "1001000",              0, 3'd5});
    vecs.push_back('{"G",        "111011101000",         1, 3'd6});
    vecs.push_back('{"longmark", "11111111111000",       0, 3'd6});
    run_table();

    // Reset in mid-letter discards the partial letter silently
    saved = letter;
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b0);
    reset = 1'b1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_letter", 32'(letter), 32'd0);
    chk("midreset_pulse", 32'(letter_valid | letter_error), 32'd0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("after_reset_E_valid", 32'(letter_valid), 32'd1);
    chk("after_reset_E_letter", 32'(letter), 32'd4);

    // Line toggling without bit_tick changes nothing
    step(1'b1, 1'b1);
    pulse_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'(i & 1));
      if (letter_valid || letter_error || !busy) pulse_seen = 1;
    end
    chk("notick_no_change", 32'(pulse_seen), 32'd0);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("notick_not_done", 32'(letter_valid), 32'd0);
    step(1'b1, 1'b0);
    chk("notick_E_valid", 32'(letter_valid), 32'd1);
    chk("notick_E_letter", 32'(letter), 32'd4);

    run_random(300);
    repeat (4) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
